// File: rtl/app_line_echo_pkg.sv
// Shared types and ASCII constants for the line-buffered echo stage.
// The case-folding helper is used when APP_LINE_ECHO_UPPERCASE_EN is defined.
package app_line_echo_pkg;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [7:0] ASCII_LC_A        = 8'h61;
  localparam logic [7:0] ASCII_LC_Z        = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    logic [7:0] r;
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
      r = b - ASCII_CASE_OFFSET;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/app_byte_fifo.sv
// Byte FIFO with registered write and asynchronous read (LUT-RAM style).
// Push while full and pop while empty are ignored; the array itself is not reset.
module app_byte_fifo
  import app_line_echo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/app_line_echo.sv
// Line-buffered echo: collects OUT bytes until terminator, full buffer or idle
// timeout, then replays them on IN. APP_LINE_ECHO_UPPERCASE_EN folds a-z to A-Z.
module app_line_echo
  import app_line_echo_pkg::*;
#(
  parameter int         DEPTH     = 64,
  parameter logic [7:0] TERM_BYTE = 8'h0D,
  parameter int         TIMEOUT   = 2000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i
);

  localparam int          CNT_W      = $clog2(DEPTH) + 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [31:0] IDLE_LAST  = TIMEOUT_EN ? 32'(TIMEOUT - 1) : 32'd0;

  state_e           state_q, state_d;
  logic [31:0]      idle_q, idle_d;
  logic [CNT_W-1:0] count_s;
  logic [7:0]       rdata_s;
  logic             full_s, empty_s, push_s, pop_s;

  assign out_ready_o = (state_q == ST_FILL) && !full_s;
  assign in_valid_o  = (state_q == ST_DRAIN) && !empty_s;
  assign push_s      = out_ready_o && out_valid_i;
  assign pop_s       = in_valid_o && in_ready_i;

`ifdef APP_LINE_ECHO_UPPERCASE_EN
  assign in_data_o = to_upper(rdata_s);
`else
  assign in_data_o = rdata_s;
`endif

  app_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push_s),
    .wdata_i (out_data_i),
    .pop_i   (pop_s),
    .rdata_o (rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // Fill/drain sequencing and idle timeout
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    case (state_q)
      ST_FILL: begin
        if (push_s) begin
          idle_d = 32'd0;
          if (out_data_i == TERM_BYTE || count_s == CNT_W'(DEPTH - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FILL;
          end
        end else if (!empty_s) begin
          if (TIMEOUT_EN && idle_q == IDLE_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FILL;
          end
          if (idle_q != 32'hFFFF_FFFF) begin
            idle_d = idle_q + 32'd1;
          end else begin
            idle_d = idle_q;
          end
        end else begin
          state_d = ST_FILL;
          idle_d  = idle_q;
        end
      end
      ST_DRAIN: begin
        idle_d = 32'd0;
        // An empty FIFO here is unreachable in normal flow; recover to FILL.
        if ((pop_s && count_s == CNT_W'(1)) || empty_s) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_FILL;
        idle_d  = 32'd0;
      end
    endcase
  end

  // State and idle counter registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_FILL;
      idle_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: doc/app_line_echo.md
# app_line_echo

Application-side line-buffered echo stage for the CDC demo design. Sits on the app side of `usb_cdc` (clocked by the 2 MHz app clock). It consumes the OUT byte stream (host→device), buffers bytes until a terminator, a full buffer, or an idle timeout, then returns the buffered line on the IN stream (device→host). Data is stored in a FIFO, so whole lines are echoed in order.

## Interface

Parameters:
- `DEPTH`, 64 — FIFO depth in bytes; power of two, minimum 4.
- `TERM_BYTE`, 8'h0D — line terminator that triggers drain; it is stored and echoed.
- `TIMEOUT`, 2000 — idle cycles in FILL with non-empty FIFO before forced drain; 0 disables the timeout. 2000 cycles is 1 ms at 2 MHz.

Ports:
- `clk_i`  in  1  app clock; all logic on its rising edge.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `out_data_i`  in  8  OUT byte from `usb_cdc`.
- `out_valid_i`  in  1  `out_data_i` is valid.
- `out_ready_o`  out  1  block accepts an OUT byte this cycle.
- `in_data_o`  out  8  IN byte to `usb_cdc`.
- `in_valid_o`  out  1  `in_data_o` is valid.
- `in_ready_i`  in  1  `usb_cdc` accepts the IN byte this cycle.

## Operation

- Handshake: a transfer occurs on a rising edge where valid && ready. Once `in_valid_o` is raised, it and `in_data_o` hold stable until accepted.
- States: FILL (reset state) and DRAIN.
- FILL:
  - `out_ready_o` = !full; `in_valid_o` = 0.
  - Each accepted byte is written at the write pointer and the count increments.
  - Go to DRAIN on the edge that accepts `TERM_BYTE`.
  - Go to DRAIN on the edge that makes count == DEPTH, regardless of byte value.
  - Go to DRAIN when the idle counter reaches TIMEOUT−1 with count > 0.
- DRAIN:
  - `out_ready_o` = 0; `in_valid_o` = (count > 0); `in_data_o` = mem[rd_ptr].
  - Each accepted byte advances rd_ptr and decrements count.
  - Go to FILL on the edge that pops the last byte (count 1→0).
- FIFO has no simultaneous read and write: writes occur only in FILL, reads only in DRAIN.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits; full = (count == DEPTH), empty = (count == 0).
- Idle counter (32-bit saturating):
  - Cleared on reset, on every accepted OUT byte, and in DRAIN.
  - Increments in FILL while count > 0 and no byte is accepted.
- Reset mid-operation (`rstn_i` low at an edge): state = FILL, pointers, count and idle counter = 0; buffered data is discarded.
- Reset output values: `out_ready_o` = 1 (FILL, empty), `in_valid_o` = 0, `in_data_o` = don't-care (bench checks it only when valid).

## Timing

- `out_ready_o` and `in_valid_o` are combinational from registered state and count only; there are no combinational paths from `*_valid_i`/`*_ready_i`.
- Terminator accepted at edge N → state DRAIN after N → `in_valid_o` = 1 in the cycle following edge N, showing the first byte of the line.
- With `in_ready_i` held high, DRAIN sustains one byte per cycle. `out_ready_o` returns high in the cycle after the last pop.
- Timeout: the last byte accepted at edge N forces DRAIN after edge N+TIMEOUT (TIMEOUT ≥ 1).
- Memory: write is registered; read is asynchronous from the array (LUT RAM). The array is not reset.

## Configuration

- `APP_LINE_ECHO_UPPERCASE_EN`:
  - Defined: `in_data_o` maps 8'h61–8'h7A to 8'h41–8'h5A (subtract 8'h20); all other values pass unchanged. The conversion is combinational on the FIFO output.
  - Undefined: bytes are echoed verbatim.
  - Stored data is identical in both cases.

## Structure

- Shared package `app_line_echo_pkg`:
  - State typedef (FILL, DRAIN).
  - Constants `ASCII_LC_A` = 8'h61, `ASCII_LC_Z` = 8'h7A, `ASCII_CASE_OFFSET` = 8'h20.
- Sub-module `app_byte_fifo` (DEPTH, 8-bit, push/pop/full/empty/count). The FSM and idle counter stay in the top.

## Test plan

- Send "ab" + 0x0D with `in_ready_i` = 1 → IN stream is 0x61 0x62 0x0D; `in_valid_o` rises the cycle after 0x0D is accepted; `out_ready_o` = 0 until the last pop. With the macro defined, expect 0x41 0x42 0x0D.
- Send 64 bytes 0x00..0x3F with no terminator (DEPTH = 64) → `out_ready_o` falls after byte 64; echo is 0x00..0x3F in order; pointers wrap; a second identical burst echoes identically.
- Send "x", then idle with TIMEOUT = 10 → `in_valid_o` = 0 through edge N+9 and rises after edge N+10; the byte returned is 0x78.
- IN backpressure: during DRAIN, toggle `in_ready_i` 1,0,0,1 → `in_data_o` stays stable while not accepted; no byte is lost or duplicated.
- Assert `rstn_i` low for one edge mid-DRAIN with 3 bytes left → next cycle `in_valid_o` = 0, `out_ready_o` = 1; a new line "z" + 0x0D echoes only 0x7A 0x0D.
- Send 0x0D alone into an empty FIFO → one byte, 0x0D, echoed, then return to FILL.
